// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: arbitrates NUM_PORTS requesters onto one single-port word SRAM
// that has a 1-cycle read. It builds byte-lane strobes from addr[1:0] and size,
// lane-shifts write data, lane-aligns read data, and rejects misaligned or
// reserved-size accesses with an error acknowledge.
//
// Optional feature: when DMA_FIXED_PRIO_EN is defined, arbitration is fixed
// priority and the lowest index wins. When it is undefined (the default),
// arbitration is round-robin.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req/req_we        per-port request and write flag; held until gnt
//   req_size          per-port size (00 byte, 01 half, 10 word, 11 reserved)
//   req_addr          per-port byte address
//   req_wdata         per-port write data, LSB-justified
//   gnt               one-hot grant, combinational, in the cycle of acceptance
//   rvalid/rerr       1-cycle response one cycle after grant (read data or error)
//   rdata             read data, LSB-justified, zero-extended; holds when idle
//   mem_en/mem_we     RAM enable and byte write strobes
//   mem_addr/mem_di   RAM word address and lane-positioned write data
//   mem_do            RAM read data, valid the cycle after a read enable
module data_mem_arbiter #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_AW    = 11
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          req_we,
  input  logic [2*NUM_PORTS-1:0]        req_size,
  input  logic [ADDR_W*NUM_PORTS-1:0]   req_addr,
  input  logic [DATA_W*NUM_PORTS-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS-1:0]          rerr,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_en,
  output logic [3:0]                    mem_we,
  output logic [MEM_AW-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_di,
  input  logic [DATA_W-1:0]             mem_do
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic              hit;
  logic [PW-1:0]     sel;
  logic [MEM_AW+1:0] addr;
  logic [1:0]        off;
  logic [1:0]        size;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        strb;
  logic              err;

  logic              rsp_vld;
  logic              rsp_err;
  logic [PW-1:0]     rsp_port;
  logic [1:0]        rsp_off;
  logic [1:0]        rsp_size;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] aligned;

`ifdef DMA_FIXED_PRIO_EN
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[PW'(i)]) begin
        hit = 1'b1;
        sel = PW'(i);
      end
    end
    if (!rst_n) begin
      hit = 1'b0;
      sel = '0;
    end
  end
`else
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;

  // Round-robin: scan ports starting at ptr and take the first requester.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = PW'((32'(ptr) + i) % NUM_PORTS);
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    if (!rst_n) begin
      hit = 1'b0;
      sel = '0;
    end
  end

  // After each grant, the pointer moves to the port that follows the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (hit) begin
      ptr <= (32'(sel) == NUM_PORTS - 1) ? '0 : sel + PW'(1);
    end
  end
`endif

  // Decode the selected port's request.
  always_comb begin
    addr  = req_addr[32'(sel)*ADDR_W +: MEM_AW+2];
    size  = req_size[32'(sel)*2 +: 2];
    we    = req_we[sel];
    wdata = req_wdata[32'(sel)*DATA_W +: DATA_W];
    off   = addr[1:0];
    case (size)
      2'b00:   strb = 4'b0001 << off;
      2'b01:   strb = 4'b0011 << off;
      default: strb = 4'b1111;
    endcase
    err = (size == 2'b11) || (size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00);
  end

  assign gnt      = hit ? (NUM_PORTS'(1) << sel) : '0;
  assign mem_en   = hit && !err;
  assign mem_we   = (hit && !err && we) ? strb : 4'b0000;
  assign mem_addr = addr[MEM_AW+1:2];
  assign mem_di   = wdata << {off, 3'b000};

  // Response tag: good writes produce no response; reads and errors respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld  <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_port <= '0;
      rsp_off  <= 2'b00;
      rsp_size <= 2'b00;
      rdata_q  <= '0;
    end else begin
      rsp_vld <= hit && (err || !we);
      rsp_err <= hit && err;
      if (hit) begin
        rsp_port <= sel;
        rsp_off  <= off;
        rsp_size <= size;
      end
      rdata_q <= rdata;
    end
  end

  // The RAM output arrives in the response cycle, so it is aligned here and
  // held in rdata_q for the idle cycles that follow.
  always_comb begin
    shifted = mem_do >> {rsp_off, 3'b000};
    case (rsp_size)
      2'b00:   aligned = DATA_W'(shifted[7:0]);
      2'b01:   aligned = DATA_W'(shifted[15:0]);
      default: aligned = shifted;
    endcase
    rdata = rdata_q;
    if (rsp_vld) begin
      rdata = rsp_err ? '0 : aligned;
    end
  end

  assign rvalid = rsp_vld ? (NUM_PORTS'(1) << rsp_port) : '0;
  assign rerr   = (rsp_vld && rsp_err) ? (NUM_PORTS'(1) << rsp_port) : '0;

endmodule
